// File: rtl/haraka_rc_bank.sv
// haraka_rc_bank: round-constant bank for the Haraka-S datapath.
// Constants arrive once as a load stream (one beat per cycle), then each
// `start` replays them in order over a valid/ready stream that feeds the
// per-round pipeline register.
//
// Build option: define HARAKA_RC_RELOAD_EN to allow a fresh load stream to
// be accepted from IDLE (the first beat overwrites entry 0 and re-enters
// LOAD). Without it, the constants are fixed until the next reset.
//
// state  | meaning
// -------+-----------------------------------------------------------
// LOAD   | accepting load beats, wr_ptr advancing 0..NUM_RC-1
// IDLE   | all constants loaded, waiting for start
// STREAM | replaying constants, rc_index advancing on each handshake
module haraka_rc_bank #(
    parameter int NUM_RC = 40,
    parameter int RC_W   = 128,
    parameter int IDX_W  = $clog2(NUM_RC)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [RC_W-1:0]  load_data,
    output logic             load_ready,
    input  logic             start,
    output logic             rc_valid,
    input  logic             rc_ready,
    output logic [RC_W-1:0]  rc_out,
    output logic [IDX_W-1:0] rc_index,
    output logic             rc_last,
    output logic             loaded,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_IDLE   = 2'd1,
        S_STREAM = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RC - 1);

`ifdef HARAKA_RC_RELOAD_EN
    localparam logic IDLE_LOAD_READY = 1'b1;
`else
    localparam logic IDLE_LOAD_READY = 1'b0;
`endif

    logic [RC_W-1:0]  mem_q [NUM_RC];

    state_t           state_q,      state_d;
    logic [IDX_W-1:0] wr_ptr_q,     wr_ptr_d;
    logic             load_ready_q, load_ready_d;
    logic             loaded_q,     loaded_d;
    logic             rc_valid_q,   rc_valid_d;
    logic [RC_W-1:0]  rc_out_q,     rc_out_d;
    // rc_index doubles as the read pointer: it always names the entry
    // currently presented on rc_out.
    logic [IDX_W-1:0] rc_index_q,   rc_index_d;
    logic             rc_last_q,    rc_last_d;
    logic             busy_q,       busy_d;

    logic             mem_we;
    logic [IDX_W-1:0] mem_waddr;
    logic [IDX_W-1:0] idx_nxt;

    assign idx_nxt = rc_index_q + IDX_W'(1);

    // Next-state and next-output computation for the load/replay FSM.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        load_ready_d = load_ready_q;
        loaded_d     = loaded_q;
        rc_valid_d   = rc_valid_q;
        rc_out_d     = rc_out_q;
        rc_index_d   = rc_index_q;
        rc_last_d    = rc_last_q;
        busy_d       = busy_q;
        mem_we       = 1'b0;
        mem_waddr    = wr_ptr_q;

        case (state_q)
            S_LOAD: begin
                if (load_valid && load_ready_q) begin
                    mem_we    = 1'b1;
                    mem_waddr = wr_ptr_q;
                    if (wr_ptr_q == LAST_IDX) begin
                        wr_ptr_d     = '0;
                        loaded_d     = 1'b1;
                        load_ready_d = IDLE_LOAD_READY;
                        state_d      = S_IDLE;
                    end else begin
                        wr_ptr_d = wr_ptr_q + IDX_W'(1);
                    end
                end
            end

            S_IDLE: begin
`ifdef HARAKA_RC_RELOAD_EN
                // A new load stream takes priority over a coincident start.
                if (load_valid && load_ready_q) begin
                    mem_we    = 1'b1;
                    mem_waddr = '0;
                    wr_ptr_d  = IDX_W'(1);
                    loaded_d  = 1'b0;
                    state_d   = S_LOAD;
                end else if (start) begin
`else
                if (start) begin
`endif
                    rc_out_d     = mem_q[0];
                    rc_index_d   = '0;
                    rc_last_d    = (LAST_IDX == '0);
                    rc_valid_d   = 1'b1;
                    busy_d       = 1'b1;
                    load_ready_d = 1'b0;
                    state_d      = S_STREAM;
                end
            end

            S_STREAM: begin
                if (rc_valid_q && rc_ready) begin
                    if (rc_last_q) begin
                        rc_valid_d   = 1'b0;
                        busy_d       = 1'b0;
                        rc_last_d    = 1'b0;
                        rc_index_d   = '0;
                        load_ready_d = IDLE_LOAD_READY;
                        state_d      = S_IDLE;
                    end else begin
                        rc_out_d   = mem_q[idx_nxt];
                        rc_index_d = idx_nxt;
                        rc_last_d  = (idx_nxt == LAST_IDX);
                    end
                end
            end

            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    // Control and output registers; reset puts the bank back into LOAD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_LOAD;
            wr_ptr_q     <= '0;
            load_ready_q <= 1'b1;
            loaded_q     <= 1'b0;
            rc_valid_q   <= 1'b0;
            rc_out_q     <= '0;
            rc_index_q   <= '0;
            rc_last_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            load_ready_q <= load_ready_d;
            loaded_q     <= loaded_d;
            rc_valid_q   <= rc_valid_d;
            rc_out_q     <= rc_out_d;
            rc_index_q   <= rc_index_d;
            rc_last_q    <= rc_last_d;
            busy_q       <= busy_d;
        end
    end

    // Constant storage; intentionally not reset, contents are meaningless
    // until a full load completes.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= load_data;
        end
    end

    assign load_ready = load_ready_q;
    assign loaded     = loaded_q;
    assign rc_valid   = rc_valid_q;
    assign rc_out     = rc_out_q;
    assign rc_index   = rc_index_q;
    assign rc_last    = rc_last_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_haraka_rc_bank.sv
// Directed testbench for haraka_rc_bank (default parameters).
module tb_haraka_rc_bank;

    localparam int NUM_RC = 40;
    localparam int RC_W   = 128;
    localparam int IDX_W  = 6;

`ifdef HARAKA_RC_RELOAD_EN
    localparam logic EXP_IDLE_READY = 1'b1;
`else
    localparam logic EXP_IDLE_READY = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic             load_valid;
    logic [RC_W-1:0]  load_data;
    logic             load_ready;
    logic             start;
    logic             rc_valid;
    logic             rc_ready;
    logic [RC_W-1:0]  rc_out;
    logic [IDX_W-1:0] rc_index;
    logic             rc_last;
    logic             loaded;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    haraka_rc_bank #(.NUM_RC(NUM_RC), .RC_W(RC_W), .IDX_W(IDX_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .start      (start),
        .rc_valid   (rc_valid),
        .rc_ready   (rc_ready),
        .rc_out     (rc_out),
        .rc_index   (rc_index),
        .rc_last    (rc_last),
        .loaded     (loaded),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        reset = 1'b1; load_valid = 1'b0; load_data = '0; start = 1'b0; rc_ready = 1'b0;
        #3;
        checks++;
        if ({load_ready, loaded, rc_valid, rc_index, rc_last, busy} !== {1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_ctrl got lr=%b ld=%b v=%b idx=%0d last=%b busy=%b", load_ready, loaded, rc_valid, rc_index, rc_last, busy);
        end
        checks++;
        if (rc_out !== '0) begin
            failures++;
            $display("FAIL reset_rc_out got %h expected 0", rc_out);
        end
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({load_ready, loaded, rc_valid} !== 3'b100) begin
            failures++;
            $display("FAIL post_reset got lr=%b ld=%b v=%b expected 1 0 0", load_ready, loaded, rc_valid);
        end
    endtask

    // Full load of base+i; a start pulse on beat 10 must be ignored.
    task automatic test_load(input int base);
        for (int i = 0; i < NUM_RC; i++) begin
            checks++;
            if (load_ready !== 1'b1) begin
                failures++;
                $display("FAIL load_ready_beat%0d got %b expected 1", i, load_ready);
            end
            load_valid = 1'b1;
            load_data  = RC_W'(base + i);
            start      = (i == 10);
            @(posedge clk); #1;
            start = 1'b0;
            if (i == 10) begin
                checks++;
                if ({rc_valid, busy} !== 2'b00) begin
                    failures++;
                    $display("FAIL start_in_load got v=%b busy=%b expected 0 0", rc_valid, busy);
                end
            end
            if (i == NUM_RC - 2) begin
                checks++;
                if (loaded !== 1'b0) begin
                    failures++;
                    $display("FAIL loaded_early got %b expected 0", loaded);
                end
            end
        end
        load_valid = 1'b0;
        checks++;
        if ({loaded, load_ready, rc_valid} !== {1'b1, EXP_IDLE_READY, 1'b0}) begin
            failures++;
            $display("FAIL load_done got ld=%b lr=%b v=%b expected 1 %b 0", loaded, load_ready, rc_valid, EXP_IDLE_READY);
        end
    endtask

    // Replay with rc_ready held high; expects base+k on cycle k after start.
    task automatic test_replay(input int base);
        rc_ready = 1'b1;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < NUM_RC; k++) begin
            checks++;
            if ({rc_valid, rc_index, rc_last, busy, load_ready} !== {1'b1, 6'(k), (k == NUM_RC - 1), 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL replay_ctrl_k%0d got v=%b idx=%0d last=%b busy=%b lr=%b", k, rc_valid, rc_index, rc_last, busy, load_ready);
            end
            checks++;
            if (rc_out !== RC_W'(base + k)) begin
                failures++;
                $display("FAIL replay_data_k%0d got %0d expected %0d", k, rc_out, base + k);
            end
            @(posedge clk); #1;
        end
        checks++;
        if ({rc_valid, busy, rc_last, load_ready} !== {1'b0, 1'b0, 1'b0, EXP_IDLE_READY}) begin
            failures++;
            $display("FAIL replay_end got v=%b busy=%b last=%b lr=%b", rc_valid, busy, rc_last, load_ready);
        end
    endtask

    // Starts in the bubble after a replay; stalls 3 cycles at index 5
    // with a start pulse mid-stall that must be ignored.
    task automatic test_stall_back_to_back;
        rc_ready = 1'b1;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < NUM_RC; k++) begin
            checks++;
            if ({rc_valid, rc_index, rc_last} !== {1'b1, 6'(k), (k == NUM_RC - 1)} || rc_out !== RC_W'(k)) begin
                failures++;
                $display("FAIL stall_stream_k%0d got v=%b idx=%0d last=%b out=%0d", k, rc_valid, rc_index, rc_last, rc_out);
            end
            if (k == 5) begin
                rc_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    start = (s == 1);
                    @(posedge clk); #1;
                    checks++;
                    if ({rc_valid, rc_index, rc_last, busy} !== {1'b1, 6'd5, 1'b0, 1'b1} || rc_out !== RC_W'(5)) begin
                        failures++;
                        $display("FAIL stall_hold_s%0d got v=%b idx=%0d out=%0d expected idx 5 out 5", s, rc_valid, rc_index, rc_out);
                    end
                end
                start    = 1'b0;
                rc_ready = 1'b1;
            end
            @(posedge clk); #1;
        end
        checks++;
        if ({rc_valid, busy} !== 2'b00) begin
            failures++;
            $display("FAIL stall_end got v=%b busy=%b expected 0 0", rc_valid, busy);
        end
    endtask

    task automatic test_reset_mid_replay;
        rc_ready = 1'b1;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
        end
        checks++;
        if (rc_index !== 6'd20 || rc_out !== RC_W'(20)) begin
            failures++;
            $display("FAIL pre_reset_idx got idx=%0d out=%0d expected 20", rc_index, rc_out);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({load_ready, loaded, rc_valid, rc_index, rc_last, busy} !== {1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0} || rc_out !== '0) begin
            failures++;
            $display("FAIL async_reset got lr=%b ld=%b v=%b idx=%0d busy=%b out=%0d", load_ready, loaded, rc_valid, rc_index, busy, rc_out);
        end
        @(negedge clk); reset = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({rc_valid, busy, loaded, load_ready} !== 4'b0001) begin
            failures++;
            $display("FAIL start_after_reset got v=%b busy=%b ld=%b lr=%b expected 0 0 0 1", rc_valid, busy, loaded, load_ready);
        end
    endtask

`ifdef HARAKA_RC_RELOAD_EN
    task automatic test_reload;
        rc_ready = 1'b1;
        for (int i = 0; i < NUM_RC; i++) begin
            checks++;
            if (load_ready !== 1'b1) begin
                failures++;
                $display("FAIL reload_ready_beat%0d got %b expected 1", i, load_ready);
            end
            load_valid = 1'b1;
            load_data  = RC_W'(100 + i);
            start      = (i == 0);
            @(posedge clk); #1;
            start = 1'b0;
            if (i == 0) begin
                checks++;
                if ({rc_valid, busy, loaded} !== 3'b000) begin
                    failures++;
                    $display("FAIL reload_first_beat got v=%b busy=%b ld=%b expected 0 0 0", rc_valid, busy, loaded);
                end
            end
        end
        load_valid = 1'b0;
        checks++;
        if ({loaded, rc_valid} !== 2'b10) begin
            failures++;
            $display("FAIL reload_done got ld=%b v=%b expected 1 0", loaded, rc_valid);
        end
    endtask
`else
    task automatic test_no_reload;
        load_valid = 1'b1;
        load_data  = RC_W'(999);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({load_ready, loaded, rc_valid} !== 3'b010) begin
                failures++;
                $display("FAIL no_reload_c%0d got lr=%b ld=%b v=%b expected 0 1 0", i, load_ready, loaded, rc_valid);
            end
        end
        load_valid = 1'b0;
    endtask
`endif

    initial begin
        reset = 1'b1;
        test_reset();
        test_load(0);
        test_replay(0);
        test_stall_back_to_back();
        test_reset_mid_replay();
        test_load(0);
`ifdef HARAKA_RC_RELOAD_EN
        test_reload();
        test_replay(100);
`else
        test_no_reload();
        test_replay(0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
